// File: rtl/conway_pkg.sv
// Shared constants for the Life engine and its VGA display stage: grid size,
// 640x480@60 timing and the cell-to-bit mapping of the generation vector.
package conway_pkg;

   localparam int GRID_W  = 64;
   localparam int GRID_H  = 48;
   localparam int CELLS   = GRID_W * GRID_H;
   localparam int CELL_PX = 10;

   localparam int H_ACTIVE = 640;
   localparam int H_FP     = 16;
   localparam int H_SYNC   = 96;
   localparam int H_BP     = 48;
   localparam int V_ACTIVE = 480;
   localparam int V_FP     = 10;
   localparam int V_SYNC   = 2;
   localparam int V_BP     = 33;

   // 4:4:4 pixel colour {R,G,B}
   typedef logic [11:0] rgb_t;

   // Bit position of cell (row r, col c) in the generation vector.
   // Rows above GRID_H-1 (blanking) still yield an index below 4096.
   function automatic logic [11:0] cell_idx(input logic [5:0] r, input logic [5:0] c);
      return 12'(r) * 12'(GRID_W) + 12'(c);
   endfunction

endpackage

// File: rtl/conway_vga_render_if.sv
// Display-stage bus: generation vector and pause in, VGA pins and the
// generation-advance pulse out. The render stage is the master.
interface conway_vga_render_if;
   import conway_pkg::*;

   logic [CELLS-1:0] state_in;
   logic             pause;
   logic             gen_tick;
   logic             hsync;
   logic             vsync;
   logic             de;
   rgb_t             rgb;

   modport master (
      input  state_in, pause,
      output gen_tick, hsync, vsync, de, rgb
   );

   modport slave (
      output state_in, pause,
      input  gen_tick, hsync, vsync, de, rgb
   );

endinterface

// File: rtl/conway_vga_timing.sv
// Raster timing: h/v counters, per-cell sub-pixel and cell counters, raw
// sync/de and the once-per-frame snapshot strobe at (h=0, v=V_ACT).
module conway_vga_timing
   import conway_pkg::*;
#(
   parameter int H_ACT    = H_ACTIVE,
   parameter int H_FRONT  = H_FP,
   parameter int H_SYNC_W = H_SYNC,
   parameter int H_BACK   = H_BP,
   parameter int V_ACT    = V_ACTIVE,
   parameter int V_FRONT  = V_FP,
   parameter int V_SYNC_W = V_SYNC,
   parameter int V_BACK   = V_BP
) (
   input  logic       clk,
   input  logic       rst,
   output logic [3:0] o_x_sub,
   output logic [3:0] o_y_sub,
   output logic [5:0] o_col,
   output logic [5:0] o_row,
   output logic       o_hsync,
   output logic       o_vsync,
   output logic       o_de,
   output logic       o_snap_stb
);

   localparam logic [9:0] H_LAST  = 10'(H_ACT + H_FRONT + H_SYNC_W + H_BACK - 1);
   localparam logic [9:0] H_SS    = 10'(H_ACT + H_FRONT);
   localparam logic [9:0] H_SE    = 10'(H_ACT + H_FRONT + H_SYNC_W);
   localparam logic [9:0] H_DE    = 10'(H_ACT);
   localparam logic [9:0] V_LAST  = 10'(V_ACT + V_FRONT + V_SYNC_W + V_BACK - 1);
   localparam logic [9:0] V_SS    = 10'(V_ACT + V_FRONT);
   localparam logic [9:0] V_SE    = 10'(V_ACT + V_FRONT + V_SYNC_W);
   localparam logic [9:0] V_DE    = 10'(V_ACT);
   localparam logic [3:0] SUB_END = 4'(CELL_PX - 1);

   logic [9:0] r_h;
   logic [9:0] r_v;
   logic [3:0] r_x_sub;
   logic [3:0] r_y_sub;
   logic [5:0] r_col;
   logic [5:0] r_row;

   // Horizontal position; x_sub/col step with h so no divider is needed.
   // col overruns harmlessly in blanking and clears at end of line.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_h     <= '0;
         r_x_sub <= '0;
         r_col   <= '0;
      end else if (r_h == H_LAST) begin
         r_h     <= '0;
         r_x_sub <= '0;
         r_col   <= '0;
      end else begin
         r_h <= r_h + 10'd1;
         if (r_x_sub == SUB_END) begin
            r_x_sub <= '0;
            r_col   <= r_col + 6'd1;
         end else begin
            r_x_sub <= r_x_sub + 4'd1;
         end
      end
   end

   // Vertical position, advanced once per line wrap; clears at end of frame.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_v     <= '0;
         r_y_sub <= '0;
         r_row   <= '0;
      end else if (r_h == H_LAST) begin
         if (r_v == V_LAST) begin
            r_v     <= '0;
            r_y_sub <= '0;
            r_row   <= '0;
         end else begin
            r_v <= r_v + 10'd1;
            if (r_y_sub == SUB_END) begin
               r_y_sub <= '0;
               r_row   <= r_row + 6'd1;
            end else begin
               r_y_sub <= r_y_sub + 4'd1;
            end
         end
      end
   end

   assign o_x_sub    = r_x_sub;
   assign o_y_sub    = r_y_sub;
   assign o_col      = r_col;
   assign o_row      = r_row;
   assign o_hsync    = ~((r_h >= H_SS) && (r_h < H_SE));
   assign o_vsync    = ~((r_v >= V_SS) && (r_v < V_SE));
   assign o_de       = (r_h < H_DE) && (r_v < V_DE);
   assign o_snap_stb = (r_h == 10'd0) && (r_v == V_DE);

endmodule

// File: rtl/conway_vga_render.sv
// Life display stage: snapshots the generation vector at the start of
// vblank, scans it out as 10x10 pixel cells, and pulses gen_tick every
// FRAMES_PER_GEN snapshots so the engine steps during vblank.
// Geometry is parameterised; the defaults give 640x480@60.
module conway_vga_render
   import conway_pkg::*;
#(
   parameter int   FRAMES_PER_GEN = 60,
   parameter rgb_t LIVE_RGB       = 12'hFFF,
   parameter rgb_t DEAD_RGB       = 12'h000,
   parameter rgb_t GRID_RGB       = 12'h222,
   parameter bit   GRID_EN        = 1'b0,
   parameter int   H_ACT          = H_ACTIVE,
   parameter int   H_FRONT        = H_FP,
   parameter int   H_SYNC_W       = H_SYNC,
   parameter int   H_BACK         = H_BP,
   parameter int   V_ACT          = V_ACTIVE,
   parameter int   V_FRONT        = V_FP,
   parameter int   V_SYNC_W       = V_SYNC,
   parameter int   V_BACK         = V_BP
) (
   input  logic                clk,
   input  logic                rst,
   conway_vga_render_if.master bus
);

   logic [3:0]  w_x_sub;
   logic [3:0]  w_y_sub;
   logic [5:0]  w_col;
   logic [5:0]  w_row;
   logic        w_hsync;
   logic        w_vsync;
   logic        w_de;
   logic        w_snap_stb;
   logic [11:0] w_cell;
   logic        w_live;
   rgb_t        w_rgb;

   logic [CELLS-1:0] r_snap;
   logic [7:0]       r_div;
   logic             r_gen_tick;
   logic             r_hsync;
   logic             r_vsync;
   logic             r_de;
   rgb_t             r_rgb;

   conway_vga_timing #(
      .H_ACT    (H_ACT),
      .H_FRONT  (H_FRONT),
      .H_SYNC_W (H_SYNC_W),
      .H_BACK   (H_BACK),
      .V_ACT    (V_ACT),
      .V_FRONT  (V_FRONT),
      .V_SYNC_W (V_SYNC_W),
      .V_BACK   (V_BACK)
   ) u_timing (
      .clk        (clk),
      .rst        (rst),
      .o_x_sub    (w_x_sub),
      .o_y_sub    (w_y_sub),
      .o_col      (w_col),
      .o_row      (w_row),
      .o_hsync    (w_hsync),
      .o_vsync    (w_vsync),
      .o_de       (w_de),
      .o_snap_stb (w_snap_stb)
   );

   assign w_cell = cell_idx(w_row, w_col);
   assign w_live = (w_cell < 12'(CELLS)) ? r_snap[w_cell] : 1'b0;

   // Colour for the current raster position; black outside the visible area.
   always_comb begin
      w_rgb = 12'h000;
      if (w_de) begin
         if (GRID_EN && ((w_x_sub == 4'd0) || (w_y_sub == 4'd0))) begin
            w_rgb = GRID_RGB;
         end else begin
            w_rgb = w_live ? LIVE_RGB : DEAD_RGB;
         end
      end
   end

   // Snapshot capture and frame divider; the tick lands the cycle after the
   // snapshot. The divider wraps whether or not pause suppresses the pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_snap     <= '0;
         r_div      <= '0;
         r_gen_tick <= 1'b0;
      end else begin
         r_gen_tick <= 1'b0;
         if (w_snap_stb) begin
            r_snap <= bus.state_in;
            if (r_div == 8'(FRAMES_PER_GEN - 1)) begin
               r_div      <= '0;
               r_gen_tick <= ~bus.pause;
            end else begin
               r_div <= r_div + 8'd1;
            end
         end
      end
   end

   // Pixel output stage: sync, de and colour registered together.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_hsync <= 1'b1;
         r_vsync <= 1'b1;
         r_de    <= 1'b0;
         r_rgb   <= 12'h000;
      end else begin
         r_hsync <= w_hsync;
         r_vsync <= w_vsync;
         r_de    <= w_de;
         r_rgb   <= w_rgb;
      end
   end

   assign bus.gen_tick = r_gen_tick;
   assign bus.hsync    = r_hsync;
   assign bus.vsync    = r_vsync;
   assign bus.de       = r_de;
   assign bus.rgb      = r_rgb;

endmodule

// File: tb/tb_conway_vga_render.sv
// Bench for conway_vga_render: a full 640x480 instance for line timing and a
// reduced-geometry instance for whole-frame behaviour, both checked every
// cycle against a position/arithmetic reference model.
module tb_conway_vga_render;
   import conway_pkg::*;

   // reduced geometry: 4x3 visible cells, 56x36 total
   localparam int S_HA = 40, S_HF = 4, S_HS = 8, S_HB = 4;
   localparam int S_VA = 30, S_VF = 2, S_VS = 2, S_VB = 2;
   localparam int S_HT = S_HA + S_HF + S_HS + S_HB;
   localparam int S_FT = S_HT * (S_VA + S_VF + S_VS + S_VB);

   int   g_ha  [2] = '{640, S_HA};
   int   g_hf  [2] = '{16,  S_HF};
   int   g_hs  [2] = '{96,  S_HS};
   int   g_hb  [2] = '{48,  S_HB};
   int   g_va  [2] = '{480, S_VA};
   int   g_vf  [2] = '{10,  S_VF};
   int   g_vs  [2] = '{2,   S_VS};
   int   g_vb  [2] = '{33,  S_VB};
   int   g_fpg [2] = '{60,  4};
   rgb_t g_live[2] = '{12'hFFF, 12'hF80};
   rgb_t g_dead[2] = '{12'h000, 12'h00F};
   rgb_t g_grid[2] = '{12'h222, 12'h5A5};
   bit   g_gen [2] = '{1'b0, 1'b1};

   logic clk = 1'b0;
   logic rst_f;
   logic rst_s;

   conway_vga_render_if vif_f ();
   conway_vga_render_if vif_s ();

   conway_vga_render dut_f (
      .clk (clk),
      .rst (rst_f),
      .bus (vif_f)
   );

   conway_vga_render #(
      .FRAMES_PER_GEN (4),
      .LIVE_RGB (12'hF80), .DEAD_RGB (12'h00F), .GRID_RGB (12'h5A5), .GRID_EN (1'b1),
      .H_ACT (S_HA), .H_FRONT (S_HF), .H_SYNC_W (S_HS), .H_BACK (S_HB),
      .V_ACT (S_VA), .V_FRONT (S_VF), .V_SYNC_W (S_VS), .V_BACK (S_VB)
   ) dut_s (
      .clk (clk),
      .rst (rst_s),
      .bus (vif_s)
   );

   // clock
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // model state
   int               k;
   logic [CELLS-1:0] m_snap;
   int               m_snaps;
   int               m_ticks = 0;
   int               o_ticks = 0;
   int               hs_fall, vs_fall, de_start;
   logic             p_hs, p_vs, p_de;
   bit               hs_first, vs_first;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s (k=%0d): got %0h expected %0h", tag, k, got, exp);
      end
   endtask

   function automatic logic [CELLS-1:0] rand_state();
      logic [CELLS-1:0] s;
      for (int i = 0; i < CELLS / 32; i++) s[i*32 +: 32] = $urandom();
      return s;
   endfunction

   task automatic model_reset();
      k        = 0;
      m_snap   = '0;
      m_snaps  = 0;
      hs_fall  = -1;
      vs_fall  = -1;
      de_start = -1;
      p_hs     = 1'b1;
      p_vs     = 1'b1;
      p_de     = 1'b0;
      hs_first = 1'b0;
      vs_first = 1'b0;
   endtask

   task automatic check_idle(input int sel, input string tag);
      logic [15:0] got;
      if (sel == 0) got = {vif_f.hsync, vif_f.vsync, vif_f.de, vif_f.rgb, vif_f.gen_tick};
      else          got = {vif_s.hsync, vif_s.vsync, vif_s.de, vif_s.rgb, vif_s.gen_tick};
      check(tag, 32'(got), 32'h0000_C000);
   endtask

   // One clock: compare the outputs for raster position k (k clocks after
   // reset release) with the reference, then fold in snapshot/tick events.
   task automatic step(input int sel);
      logic [15:0]      got, exp;
      logic [CELLS-1:0] st;
      logic             pz;
      rgb_t             col;
      int               ht, vt, h, v;
      bit               vis, strobe, tick;
      @(posedge clk);
      #1;
      if (sel == 0) begin
         got = {vif_f.hsync, vif_f.vsync, vif_f.de, vif_f.rgb, vif_f.gen_tick};
         st  = vif_f.state_in;
         pz  = vif_f.pause;
      end else begin
         got = {vif_s.hsync, vif_s.vsync, vif_s.de, vif_s.rgb, vif_s.gen_tick};
         st  = vif_s.state_in;
         pz  = vif_s.pause;
      end
      ht = g_ha[sel] + g_hf[sel] + g_hs[sel] + g_hb[sel];
      vt = g_va[sel] + g_vf[sel] + g_vs[sel] + g_vb[sel];
      h  = k % ht;
      v  = (k / ht) % vt;
      vis = (h < g_ha[sel]) && (v < g_va[sel]);
      col = 12'h000;
      if (vis) begin
         if (g_gen[sel] && ((h % 10 == 0) || (v % 10 == 0))) col = g_grid[sel];
         else if (m_snap[(v / 10) * 64 + (h / 10)])          col = g_live[sel];
         else                                                  col = g_dead[sel];
      end
      strobe = (h == 0) && (v == g_va[sel]);
      tick   = strobe && (m_snaps % g_fpg[sel] == g_fpg[sel] - 1) && !pz;
      exp = {!(h >= g_ha[sel] + g_hf[sel] && h < g_ha[sel] + g_hf[sel] + g_hs[sel]),
             !(v >= g_va[sel] + g_vf[sel] && v < g_va[sel] + g_vf[sel] + g_vs[sel]),
             vis, col, tick};
      check("pix", 32'(got), 32'(exp));
      if (tick)   m_ticks++;
      if (got[0]) o_ticks++;
      if (strobe) begin
         m_snap = st;
         m_snaps++;
      end
      // sync and de pulse geometry measured on the actual outputs
      if (p_hs && !got[15]) begin
         if (!hs_first) check("hs_first", k, g_ha[sel] + g_hf[sel]);
         else           check("hs_period", k - hs_fall, ht);
         hs_first = 1'b1;
         hs_fall  = k;
      end
      if (!p_hs && got[15] && hs_fall >= 0) check("hs_low", k - hs_fall, g_hs[sel]);
      if (p_vs && !got[14]) begin
         if (!vs_first) check("vs_first", k, (g_va[sel] + g_vf[sel]) * ht);
         else           check("vs_period", k - vs_fall, ht * vt);
         vs_first = 1'b1;
         vs_fall  = k;
      end
      if (!p_vs && got[14] && vs_fall >= 0) check("vs_low", k - vs_fall, g_vs[sel] * ht);
      if (!p_de && got[13]) de_start = k;
      if (p_de && !got[13] && de_start >= 0) check("de_len", k - de_start, g_ha[sel]);
      p_hs = got[15];
      p_vs = got[14];
      p_de = got[13];
      k++;
   endtask

   // Per-cycle stimulus for the reduced instance, by frame f and cycle c.
   task automatic drive_small(input int f, input int c);
      logic [CELLS-1:0] s;
      if (f == 1 && c == 10 * S_HT) vif_s.state_in[65] = 1'b1;
      if (f == 2 && c == 0) begin
         s = '0;
         s[2*64+3] = 1'b1;
         s[CELLS-1] = 1'b1;
         vif_s.state_in = s;
      end
      if (f >= 3 && $urandom_range(0, 49) == 0) vif_s.state_in = rand_state();
      if (f == 7 && c == 0) vif_s.pause = 1'b1;
      if (f == 8 && c == 0) vif_s.pause = 1'b0;
      if (f >= 12 && $urandom_range(0, 299) == 0) vif_s.pause = ~vif_s.pause;
   endtask

   initial begin
      logic [CELLS-1:0] s0;
      rst_f          = 1'b0;
      rst_s          = 1'b0;
      vif_f.state_in = rand_state();
      vif_f.pause    = 1'b0;
      s0             = '0;
      s0[0]          = 1'b1;
      vif_s.state_in = s0;
      vif_s.pause    = 1'b0;
      model_reset();

      // reset values held while rst is low
      repeat (3) begin
         @(posedge clk);
         #1;
         check_idle(0, "rst_full");
         check_idle(1, "rst_small");
      end

      // full geometry: five lines of line timing
      @(negedge clk) rst_f = 1'b1;
      model_reset();
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 99) == 0) vif_f.state_in = rand_state();
         step(0);
      end
      rst_f = 1'b0;
      #1 check_idle(0, "rst_full_again");

      // reduced geometry: 16 frames, then a mid-frame reset at v=20
      @(negedge clk) rst_s = 1'b1;
      model_reset();
      for (int f = 0; f < 16; f++) begin
         for (int c = 0; c < S_FT; c++) begin
            drive_small(f, c);
            step(1);
         end
         if (f == 8) check("tick_after_pause", o_ticks, 1);
      end
      for (int c = 0; c < 20 * S_HT; c++) begin
         drive_small(16, c);
         step(1);
      end
      #2 rst_s = 1'b0;
      #1 check_idle(1, "rst_mid");
      repeat (3) begin
         @(posedge clk);
         #1 check_idle(1, "rst_hold");
      end
      @(negedge clk) rst_s = 1'b1;
      model_reset();
      for (int f = 0; f < 3; f++) begin
         for (int c = 0; c < S_FT; c++) begin
            drive_small(20, c);
            step(1);
         end
      end
      check("tick_count", o_ticks, m_ticks);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
